// File: rtl/sdp_ew_operand_dispatch_if.sv
// Valid/ready stream bundle used for the DMA beat input and both operand outputs.
interface sdp_ew_operand_dispatch_if #(
    parameter int W = 16
);
    logic [W-1:0] pd;
    logic         pvld;
    logic         prdy;

    modport master (output pd, output pvld, input prdy);
    modport slave  (input pd, input pvld, output prdy);
endinterface

// File: rtl/sdp_ew_operand_dispatch.sv
// Unpacks 64-bit element-wise DMA beats into 16-bit operands and forks them onto
// the ALU and MUL operand streams, one layer per op_en_load.
module sdp_ew_operand_dispatch #(
    parameter int DW = 16,
    parameter int BW = 64,
    parameter int CW = 24
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      op_en_load_i,
    input  logic                      reg2dp_ew_alu_bypass_i,
    input  logic                      reg2dp_ew_alu_src_i,
    input  logic                      reg2dp_ew_mul_bypass_i,
    input  logic                      reg2dp_ew_mul_src_i,
    input  logic [CW-1:0]             reg2dp_elem_num_i,
    sdp_ew_operand_dispatch_if.slave  dma_rd_i,
    sdp_ew_operand_dispatch_if.master ew_alu_in_o,
    sdp_ew_operand_dispatch_if.master ew_mul_in_o,
    output logic                      dispatch_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          aluAct_q, aluAct_d;
    logic          mulAct_q, mulAct_d;
    logic [CW-1:0] elemNum_q, elemNum_d;
    logic [CW-1:0] elemCnt_q, elemCnt_d;
    logic [1:0]    lane_q, lane_d;
    logic          beatVld_q, beatVld_d;
    logic [BW-1:0] beatPd_q, beatPd_d;
    logic          aluSent_q, aluSent_d;
    logic          mulSent_q, mulSent_d;

    logic          inRun;
    logic          bothMode;
    logic          loadAluAct;
    logic          loadMulAct;
    logic          aluVld;
    logic          mulVld;
    logic          aluFire;
    logic          mulFire;
    logic          elemDone;
    logic          lastLane;
    logic          lastElem;
    logic          beatRelease;
    logic          dmaRdy;
    logic          beatAccept;
    logic [1:0]    aluIdx;
    logic [1:0]    mulIdx;
    logic [DW-1:0] laneData [4];

    // Split the held beat into its four operand lanes, lane 0 in the low bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            laneData[i] = beatPd_q[i*DW +: DW];
        end
    end

    // Handshake, element-completion and beat-release decode for the current lane.
    always_comb begin
        inRun       = (state_q == RUN);
        bothMode    = aluAct_q & mulAct_q;
        loadAluAct  = ~reg2dp_ew_alu_bypass_i & reg2dp_ew_alu_src_i;
        loadMulAct  = ~reg2dp_ew_mul_bypass_i & reg2dp_ew_mul_src_i;
        aluVld      = inRun & beatVld_q & aluAct_q & ~aluSent_q;
        mulVld      = inRun & beatVld_q & mulAct_q & ~mulSent_q;
        aluFire     = aluVld & ew_alu_in_o.prdy;
        mulFire     = mulVld & ew_mul_in_o.prdy;
        elemDone    = inRun & beatVld_q
                    & (~aluAct_q | aluSent_q | aluFire)
                    & (~mulAct_q | mulSent_q | mulFire);
        lastLane    = bothMode ? (lane_q == 2'd1) : (lane_q == 2'd3);
        lastElem    = (elemCnt_q == elemNum_q);
        beatRelease = elemDone & (lastLane | lastElem);
        dmaRdy      = inRun & (~beatVld_q | (beatRelease & ~lastElem));
        beatAccept  = dma_rd_i.pvld & dmaRdy;
        aluIdx      = bothMode ? {lane_q[0], 1'b0} : lane_q;
        mulIdx      = bothMode ? {lane_q[0], 1'b1} : lane_q;
    end

    assign dma_rd_i.prdy    = dmaRdy;
    assign ew_alu_in_o.pvld = aluVld;
    assign ew_mul_in_o.pvld = mulVld;
    assign ew_alu_in_o.pd   = laneData[aluIdx];
    assign ew_mul_in_o.pd   = laneData[mulIdx];
    assign dispatch_done_o  = (state_q == DONE);

    // Layer sequencing: latch the config on load, walk elements, then pulse done.
    always_comb begin
        state_d   = state_q;
        aluAct_d  = aluAct_q;
        mulAct_d  = mulAct_q;
        elemNum_d = elemNum_q;
        elemCnt_d = elemCnt_q;
        lane_d    = lane_q;
        beatVld_d = beatVld_q;
        beatPd_d  = beatPd_q;
        aluSent_d = aluSent_q;
        mulSent_d = mulSent_q;

        case (state_q)
            IDLE: begin
                if (op_en_load_i) begin
                    aluAct_d  = loadAluAct;
                    mulAct_d  = loadMulAct;
                    elemNum_d = reg2dp_elem_num_i;
                    elemCnt_d = '0;
                    lane_d    = '0;
                    aluSent_d = 1'b0;
                    mulSent_d = 1'b0;
                    beatVld_d = 1'b0;
                    state_d   = (loadAluAct | loadMulAct) ? RUN : DONE;
                end
            end
            RUN: begin
                if (elemDone) begin
                    aluSent_d = 1'b0;
                    mulSent_d = 1'b0;
                    lane_d    = beatRelease ? 2'd0 : lane_q + 2'd1;
                    elemCnt_d = elemCnt_q + 1'b1;
                    if (lastElem) begin
                        state_d = DONE;
                    end
                end else begin
                    aluSent_d = aluSent_q | aluFire;
                    mulSent_d = mulSent_q | mulFire;
                end
                if (beatAccept) begin
                    beatVld_d = 1'b1;
                    beatPd_d  = dma_rd_i.pd;
                end else if (beatRelease) begin
                    beatVld_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any layer and drops a held beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q   <= IDLE;
            aluAct_q  <= 1'b0;
            mulAct_q  <= 1'b0;
            elemNum_q <= '0;
            elemCnt_q <= '0;
            lane_q    <= '0;
            beatVld_q <= 1'b0;
            beatPd_q  <= '0;
            aluSent_q <= 1'b0;
            mulSent_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aluAct_q  <= aluAct_d;
            mulAct_q  <= mulAct_d;
            elemNum_q <= elemNum_d;
            elemCnt_q <= elemCnt_d;
            lane_q    <= lane_d;
            beatVld_q <= beatVld_d;
            beatPd_q  <= beatPd_d;
            aluSent_q <= aluSent_d;
            mulSent_q <= mulSent_d;
        end
    end

endmodule

// File: tb/tb_sdp_ew_operand_dispatch.sv
// Randomized and directed bench for sdp_ew_operand_dispatch, scored against an
// operand-queue model built from the beat list and the layer configuration.
`timescale 1ns/1ps
module tb_sdp_ew_operand_dispatch;

    localparam int DW = 16;
    localparam int BW = 64;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          opEnLoad;
    logic          aluBypass;
    logic          aluSrc;
    logic          mulBypass;
    logic          mulSrc;
    logic [CW-1:0] elemNum;
    logic          done;

    sdp_ew_operand_dispatch_if #(.W(BW)) dmaIf ();
    sdp_ew_operand_dispatch_if #(.W(DW)) aluIf ();
    sdp_ew_operand_dispatch_if #(.W(DW)) mulIf ();

    sdp_ew_operand_dispatch #(.DW(DW), .BW(BW), .CW(CW)) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rstn        (rstn),
        .op_en_load_i           (opEnLoad),
        .reg2dp_ew_alu_bypass_i (aluBypass),
        .reg2dp_ew_alu_src_i    (aluSrc),
        .reg2dp_ew_mul_bypass_i (mulBypass),
        .reg2dp_ew_mul_src_i    (mulSrc),
        .reg2dp_elem_num_i      (elemNum),
        .dma_rd_i               (dmaIf),
        .ew_alu_in_o            (aluIf),
        .ew_mul_in_o            (mulIf),
        .dispatch_done_o        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit          aluActM;
    bit          mulActM;
    logic [15:0] expAlu[$];
    logic [15:0] expMul[$];
    logic [63:0] beatQ[$];
    logic [63:0] stimBeats[$];
    logic [15:0] aluLog[$];
    logic [15:0] mulLog[$];
    int          aluCyc[$];
    int          mulCyc[$];
    bit          layerOn = 1'b0;
    bit          doneDue = 1'b0;
    bit          doneNext;
    bit          acceptPending = 1'b0;
    bit          prevAccept = 1'b0;
    bit          prevAluStall = 1'b0;
    bit          prevMulStall = 1'b0;
    logic [15:0] prevAluData;
    logic [15:0] prevMulData;
    bit          randomMode = 1'b0;
    int          cycleCnt = 0;
    int          loadCyc = 0;
    int          doneCyc = 0;
    int          opsBefore;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle scoreboard: operand order, stall stability, latency, done timing, DMA ready.
    always @(negedge clk) begin
        cycleCnt++;
        if (!rstn) begin
            checkOutput("rst_alu_vld", aluIf.pvld, 0);
            checkOutput("rst_mul_vld", mulIf.pvld, 0);
            checkOutput("rst_alu_data", aluIf.pd, 0);
            checkOutput("rst_mul_data", mulIf.pd, 0);
            checkOutput("rst_dma_prdy", dmaIf.prdy, 0);
            checkOutput("rst_done", done, 0);
            layerOn       = 1'b0;
            doneDue       = 1'b0;
            acceptPending = 1'b0;
            prevAccept    = 1'b0;
            prevAluStall  = 1'b0;
            prevMulStall  = 1'b0;
        end else begin
            opsBefore = expAlu.size() + expMul.size();
            if (!(layerOn && aluActM)) checkOutput("alu_vld_inactive", aluIf.pvld, 0);
            if (!(layerOn && mulActM)) checkOutput("mul_vld_inactive", mulIf.pvld, 0);
            if (prevAluStall) begin
                checkOutput("alu_vld_held", aluIf.pvld, 1);
                checkOutput("alu_data_held", aluIf.pd, prevAluData);
            end
            if (prevMulStall) begin
                checkOutput("mul_vld_held", mulIf.pvld, 1);
                checkOutput("mul_data_held", mulIf.pd, prevMulData);
            end
            if (prevAccept) begin
                if (aluActM) checkOutput("alu_vld_after_beat", aluIf.pvld, 1);
                if (mulActM) checkOutput("mul_vld_after_beat", mulIf.pvld, 1);
            end
            if (aluIf.pvld && aluIf.prdy && layerOn && aluActM) begin
                if (expAlu.size() > 0) begin
                    checkOutput("alu_data", aluIf.pd, expAlu.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL alu_extra_operand: got 0x%0h, expected none", aluIf.pd);
                end
                aluLog.push_back(aluIf.pd);
                aluCyc.push_back(cycleCnt);
            end
            if (mulIf.pvld && mulIf.prdy && layerOn && mulActM) begin
                if (expMul.size() > 0) begin
                    checkOutput("mul_data", mulIf.pd, expMul.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL mul_extra_operand: got 0x%0h, expected none", mulIf.pd);
                end
                mulLog.push_back(mulIf.pd);
                mulCyc.push_back(cycleCnt);
            end

            checkOutput("dispatch_done", done, doneDue);
            doneNext = 1'b0;
            if (layerOn && !doneDue && opsBefore > 0 && (expAlu.size() + expMul.size()) == 0)
                doneNext = 1'b1;
            if (!layerOn) checkOutput("dma_prdy_idle", dmaIf.prdy, 0);
            if (layerOn && !aluActM && !mulActM) checkOutput("dma_prdy_no_active", dmaIf.prdy, 0);
            if (opEnLoad && !layerOn) begin
                layerOn = 1'b1;
                loadCyc = cycleCnt;
                if (!aluActM && !mulActM) doneNext = 1'b1;
            end
            if (doneDue) begin
                checkOutput("dma_prdy_done", dmaIf.prdy, 0);
                checkOutput("alu_remaining", expAlu.size(), 0);
                checkOutput("mul_remaining", expMul.size(), 0);
                layerOn = 1'b0;
                doneCyc = cycleCnt;
            end
            prevAccept = dmaIf.pvld & dmaIf.prdy;
            if (prevAccept) acceptPending = 1'b1;
            prevAluStall = aluIf.pvld & ~aluIf.prdy;
            prevMulStall = mulIf.pvld & ~mulIf.prdy;
            prevAluData  = aluIf.pd;
            prevMulData  = mulIf.pd;
            doneDue      = doneNext;
        end
    end

    // DMA source and random ready generation, updated just after each rising edge.
    initial begin
        dmaIf.pvld = 1'b0;
        dmaIf.pd   = '0;
        aluIf.prdy = 1'b0;
        mulIf.prdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (acceptPending) begin
                if (beatQ.size() > 0) void'(beatQ.pop_front());
                acceptPending = 1'b0;
            end
            if (beatQ.size() > 0) begin
                dmaIf.pd   = beatQ[0];
                dmaIf.pvld = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                dmaIf.pd   = '0;
                dmaIf.pvld = 1'b0;
            end
            if (randomMode) begin
                aluIf.prdy = ($urandom_range(0, 2) != 0);
                mulIf.prdy = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Runs one layer: builds the expected operand streams, pulses load, waits for done.
    task automatic applyStimulus(input bit aluBy, input bit aluSr, input bit mulBy, input bit mulSr,
                                 input int en, input bit rnd, input int mulLow,
                                 input bit reloadMid, input int resetAfter);
        int          per;
        int          nBeats;
        int          cnt;
        bit          both;
        bit          aborted;
        logic [63:0] b;
        aluActM = !aluBy && aluSr;
        mulActM = !mulBy && mulSr;
        both    = aluActM && mulActM;
        per     = both ? 2 : 4;
        nBeats  = (aluActM || mulActM) ? (en + per) / per : 0;
        while (stimBeats.size() < nBeats) stimBeats.push_back({$urandom(), $urandom()});
        expAlu.delete();
        expMul.delete();
        aluLog.delete();
        mulLog.delete();
        aluCyc.delete();
        mulCyc.delete();
        if (aluActM || mulActM) begin
            for (int k = 0; k <= en; k++) begin
                b = stimBeats[k / per];
                if (both) begin
                    expAlu.push_back(b[32*(k%2) +: 16]);
                    expMul.push_back(b[32*(k%2) + 16 +: 16]);
                end else if (aluActM) begin
                    expAlu.push_back(b[16*(k%4) +: 16]);
                end else begin
                    expMul.push_back(b[16*(k%4) +: 16]);
                end
            end
        end
        beatQ = stimBeats;
        stimBeats.delete();
        randomMode = rnd;
        @(posedge clk);
        #1;
        aluBypass = aluBy;
        aluSrc    = aluSr;
        mulBypass = mulBy;
        mulSrc    = mulSr;
        elemNum   = CW'(en);
        if (!rnd) begin
            aluIf.prdy = 1'b1;
            mulIf.prdy = (mulLow == 0);
        end
        opEnLoad = 1'b1;
        cnt      = 0;
        aborted  = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            opEnLoad = 1'b0;
            if (mulLow > 0 && cnt == mulLow) mulIf.prdy = 1'b1;
            if (reloadMid && cnt == 3 && (expAlu.size() + expMul.size()) > 2) opEnLoad = 1'b1;
            if (resetAfter > 0 && aluLog.size() >= resetAfter) begin
                @(negedge clk);
                #2;
                rstn = 1'b0;
                #1;
                checkOutput("rst_now_alu_vld", aluIf.pvld, 0);
                checkOutput("rst_now_mul_vld", mulIf.pvld, 0);
                checkOutput("rst_now_alu_data", aluIf.pd, 0);
                checkOutput("rst_now_dma_prdy", dmaIf.prdy, 0);
                checkOutput("rst_now_done", done, 0);
                repeat (2) @(posedge clk);
                #1;
                beatQ.delete();
                expAlu.delete();
                expMul.delete();
                rstn    = 1'b1;
                aborted = 1'b1;
            end
        end while (!aborted && layerOn && cnt < 3000);
        if (!aborted) begin
            if (layerOn) begin
                checks++;
                errors++;
                $display("[TB] FAIL layer_timeout: got no done after %0d cycles, expected done", cnt);
            end else begin
                checkOutput("beats_consumed", beatQ.size(), 0);
            end
        end
    endtask

    // Directed scenarios with hand-computed values, then randomized layers under backpressure.
    initial begin
        bit rAluBy, rAluSr, rMulBy, rMulSr;
        opEnLoad  = 1'b0;
        aluBypass = 1'b0;
        aluSrc    = 1'b0;
        mulBypass = 1'b0;
        mulSrc    = 1'b0;
        elemNum   = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] single ALU layer");
        stimBeats.push_back(64'h0004_0003_0002_0001);
        stimBeats.push_back(64'h0008_0007_0006_0005);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 0);
        checkOutput("single_alu_count", aluLog.size(), 8);
        checkOutput("single_alu_first", aluLog[0], 16'h0001);
        checkOutput("single_alu_last", aluLog[7], 16'h0008);
        checkOutput("single_mul_count", mulLog.size(), 0);
        checkOutput("single_first_cycle", aluCyc[0] - loadCyc, 2);
        checkOutput("single_last_cycle", aluCyc[7] - loadCyc, 9);
        checkOutput("single_done_cycle", doneCyc - loadCyc, 10);

        $display("[TB] both-stream fork with MUL skew");
        stimBeats.push_back(64'h00D0_00C0_00B0_00A0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 3, 1'b0, 0);
        checkOutput("fork_alu_count", aluLog.size(), 2);
        checkOutput("fork_alu_1", aluLog[1], 16'h00C0);
        checkOutput("fork_mul_0", mulLog[0], 16'h00B0);
        checkOutput("fork_alu0_cycle", aluCyc[0] - loadCyc, 2);
        checkOutput("fork_mul0_cycle", mulCyc[0] - loadCyc, 3);
        checkOutput("fork_alu1_cycle", aluCyc[1] - loadCyc, 4);
        checkOutput("fork_done_cycle", doneCyc - loadCyc, 5);

        $display("[TB] tail discard on MUL stream");
        stimBeats.push_back(64'h1004_1003_1002_1001);
        stimBeats.push_back(64'h2004_2003_2002_2001);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0, 0, 1'b0, 0);
        checkOutput("tail_mul_count", mulLog.size(), 5);
        checkOutput("tail_mul_last", mulLog[4], 16'h2001);
        repeat (3) begin
            @(negedge clk);
            checkOutput("tail_prdy_after_done", dmaIf.prdy, 0);
        end

        $display("[TB] no active stream");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0, 0, 1'b0, 0);
        checkOutput("noact_done_cycle", doneCyc - loadCyc, 1);

        $display("[TB] randomized layers with backpressure and reload");
        for (int n = 0; n < 10; n++) begin
            do begin
                rAluBy = 1'($urandom_range(0, 3) == 0);
                rAluSr = 1'($urandom_range(0, 3) != 0);
                rMulBy = 1'($urandom_range(0, 3) == 0);
                rMulSr = 1'($urandom_range(0, 3) != 0);
            end while (!((!rAluBy && rAluSr) || (!rMulBy && rMulSr)));
            applyStimulus(rAluBy, rAluSr, rMulBy, rMulSr, $urandom_range(0, 20), 1'b1, 0, 1'b1, 0);
        end

        $display("[TB] reset during a layer");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 2);
        repeat (2) @(posedge clk);
        stimBeats.push_back(64'h1111_2222_3333_4444);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 0);
        checkOutput("post_rst_count", aluLog.size(), 4);
        checkOutput("post_rst_first", aluLog[0], 16'h4444);
        checkOutput("post_rst_done_cycle", doneCyc - loadCyc, 6);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound in case a wait above never resolves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
